vc_weighted_rr_lock_arb: RTL and testbench

- Next-generation round-robin arbiter for the ring-network router output ports.
- Adds per-requester programmable weights: up to N back-to-back packets before priority rotates.
- Adds packet locking: a multi-flit grant is held until the tail flit.
- Adds a stall enable for downstream backpressure.
- All state and data ports are labelled by the static `domain` input.

---
 rtl/vc_weighted_rr_lock_arb.sv | 223 ++++++++++++++++++++++
 tb/tb_vc_weighted_rr_lock_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_weighted_rr_lock_arb.sv
// vc_weighted_rr_lock_arb
// Weighted round-robin arbiter with packet locking for ring-router output ports.
// A requester may win up to its weight in back-to-back packets before priority
// rotates past it; a multi-flit packet holds the grant until its tail flit.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   domain     static security-domain label (carried, not used by the logic)
//   en         downstream accepts the granted flit; state advances only when set
//   reqs       per-requester request
//   lasts      per-requester "current flit is a packet tail"
//   weights    packed per-requester weights, requester i at [i*p_weight_bits +: p_weight_bits]
//   grants     one-hot grant (or zero), combinational from reqs and state
//   locked     arbiter is mid-packet
//   grant_idx  binary index of the grant, 0 when no grant
//   starved    (optional) starvation override chose this cycle's winner
//
// Optional feature macro: VC_WRR_ARB_STARVE_GUARD_EN (adds p_starve_limit and starved).

module vc_weighted_rr_lock_arb #(
   parameter int unsigned p_num_reqs = 4,
   parameter int unsigned p_weight_bits = 3,
   parameter logic [p_num_reqs-1:0] p_priority_reset_value = {{(p_num_reqs-1){1'b0}}, 1'b1}
`ifdef VC_WRR_ARB_STARVE_GUARD_EN
   ,parameter int unsigned p_starve_limit = 15
`endif
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  domain,
   input  logic                                  en,
   input  logic [p_num_reqs-1:0]                 reqs,
   input  logic [p_num_reqs-1:0]                 lasts,
   input  logic [p_num_reqs*p_weight_bits-1:0]   weights,
   output logic [p_num_reqs-1:0]                 grants,
   output logic                                  locked,
   output logic [$clog2(p_num_reqs)-1:0]         grant_idx
`ifdef VC_WRR_ARB_STARVE_GUARD_EN
   ,output logic                                 starved
`endif
);

   localparam int unsigned IW = $clog2(p_num_reqs);
   localparam int unsigned WB = p_weight_bits;
   localparam int unsigned CW = p_weight_bits + 1;

   typedef enum logic {
      lk_open = 1'b0,
      lk_held = 1'b1
   } lock_state_t;

   // Domain is a label only; keep it visible without affecting logic.
   logic domain_unused;
   assign domain_unused = domain;

   function automatic logic [p_num_reqs-1:0] onehot(input logic [IW-1:0] idx);
      logic [p_num_reqs-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [IW-1:0] oh_to_idx(input logic [p_num_reqs-1:0] v);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(p_num_reqs); i++) begin
         if (v[i]) idx = IW'(i);
      end
      return idx;
   endfunction

   lock_state_t             lock_st_q, lock_st_d;
   logic [IW-1:0]           lock_idx_q, lock_idx_d;
   logic [IW-1:0]           owner_q, owner_d;
   logic [p_num_reqs-1:0]   prio_q, prio_d;
   logic [WB-1:0]           cnt_q, cnt_d;

   logic [IW-1:0]           prio_idx;
   logic [IW-1:0]           pick_idx;
   logic                    pick_found;
   int                      scan_i;
   logic [IW-1:0]           win_idx;
   logic                    win_valid;
   logic                    starve_sel;

   logic                    xfer;
   logic [WB-1:0]           wsel;
   logic [CW-1:0]           eff_w;
   logic [CW-1:0]           n_cnt;
   logic [p_num_reqs-1:0]   win_oh;

`ifdef VC_WRR_ARB_STARVE_GUARD_EN
   logic [3:0]              wait_q [p_num_reqs];
   logic [3:0]              wait_d [p_num_reqs];
   logic                    starve_hit;
   logic [IW-1:0]           starve_idx;

   // Lowest-index requester whose wait count has reached the limit.
   always_comb begin
      starve_hit = 1'b0;
      starve_idx = '0;
      for (int i = int'(p_num_reqs) - 1; i >= 0; i--) begin
         if (reqs[i] && (32'(wait_q[i]) >= p_starve_limit)) begin
            starve_hit = 1'b1;
            starve_idx = IW'(i);
         end
      end
   end

   // Wait counters saturate at 15 and clear when granted.
   always_comb begin
      for (int i = 0; i < int'(p_num_reqs); i++) begin
         wait_d[i] = wait_q[i];
         if (en) begin
            if (grants[i]) wait_d[i] = 4'd0;
            else if (reqs[i] && (wait_q[i] != 4'hf)) wait_d[i] = 4'(wait_q[i] + 4'd1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(p_num_reqs); i++) begin
         if (reset) wait_q[i] <= 4'd0;
         else       wait_q[i] <= wait_d[i];
      end
   end

   assign starved = starve_sel;
`endif

   // Variable-priority search from the priority position upward with wrap.
   // Scanning offsets high-to-low lets the smallest offset win without a break.
   always_comb begin
      prio_idx   = oh_to_idx(prio_q);
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_i     = 0;
      for (int k = int'(p_num_reqs) - 1; k >= 0; k--) begin
         scan_i = int'(prio_idx) + k;
         if (scan_i >= int'(p_num_reqs)) scan_i = scan_i - int'(p_num_reqs);
         if (reqs[scan_i]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(scan_i);
         end
      end
   end

   // Winner selection: a held lock excludes everyone but the lock owner.
   always_comb begin
      win_idx    = '0;
      win_valid  = 1'b0;
      starve_sel = 1'b0;
      if (lock_st_q == lk_held) begin
         win_idx   = lock_idx_q;
         win_valid = reqs[lock_idx_q];
      end
`ifdef VC_WRR_ARB_STARVE_GUARD_EN
      else if (starve_hit) begin
         win_idx    = starve_idx;
         win_valid  = 1'b1;
         starve_sel = 1'b1;
      end
`endif
      else begin
         win_idx   = pick_idx;
         win_valid = pick_found;
      end
      win_oh    = onehot(win_idx);
      grants    = win_valid ? win_oh : '0;
      grant_idx = win_valid ? win_idx : '0;
      locked    = (lock_st_q == lk_held);
   end

   // Next-state: lock tracking and weighted priority update on transfers.
   always_comb begin
      lock_st_d  = lock_st_q;
      lock_idx_d = lock_idx_q;
      owner_d    = owner_q;
      prio_d     = prio_q;
      cnt_d      = cnt_q;

      xfer  = en && win_valid;
      wsel  = WB'(weights >> (int'(win_idx) * int'(p_weight_bits)));
      eff_w = (wsel == '0) ? CW'(1) : {1'b0, wsel};
      n_cnt = (win_idx == owner_q) ? ({1'b0, cnt_q} + CW'(1)) : CW'(1);

      if (xfer) begin
         if (!lasts[win_idx]) begin
            lock_st_d  = lk_held;
            lock_idx_d = win_idx;
         end else begin
            lock_st_d = lk_open;
            owner_d   = win_idx;
            if (n_cnt >= eff_w) begin
               prio_d = {win_oh[p_num_reqs-2:0], win_oh[p_num_reqs-1]};
               cnt_d  = '0;
            end else begin
               prio_d = win_oh;
               cnt_d  = WB'(n_cnt);
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_st_q  <= lk_open;
         lock_idx_q <= '0;
         owner_q    <= '0;
         prio_q     <= p_priority_reset_value;
         cnt_q      <= '0;
      end else begin
         lock_st_q  <= lock_st_d;
         lock_idx_q <= lock_idx_d;
         owner_q    <= owner_d;
         prio_q     <= prio_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_vc_weighted_rr_lock_arb.sv
// Bench for vc_weighted_rr_lock_arb: directed scenarios plus random traffic
// compared against an integer-level model of the arbitration rules.

module tb_vc_weighted_rr_lock_arb;

   localparam int N  = 4;
   localparam int WB = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        domain = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  reqs = '0;
   logic [3:0]  lasts = '0;
   logic [11:0] weights = '0;
   logic [3:0]  grants;
   logic        locked;
   logic [1:0]  grant_idx;

   int checks = 0;
   int errors = 0;

   // Model state: priority position, lock, weight bookkeeping.
   int m_prio, m_lock, m_lock_idx, m_owner, m_cnt, m_win;
   logic [3:0] exp_grants;
   logic [1:0] exp_idx;
   logic       exp_locked;

   localparam logic [11:0] W_ONES = 12'b001_001_001_001;

   vc_weighted_rr_lock_arb dut (
      .clk       (clk),
      .reset     (reset),
      .domain    (domain),
      .en        (en),
      .reqs      (reqs),
      .lasts     (lasts),
      .weights   (weights),
      .grants    (grants),
      .locked    (locked),
      .grant_idx (grant_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic void model_reset();
      m_prio = 0; m_lock = 0; m_lock_idx = 0; m_owner = 0; m_cnt = 0; m_win = -1;
   endfunction

   function automatic void model_eval();
      m_win = -1;
      if (m_lock != 0) begin
         if (reqs[m_lock_idx]) m_win = m_lock_idx;
      end else begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_prio + k) % N;
            if (m_win < 0 && reqs[idx]) m_win = idx;
         end
      end
      exp_grants = (m_win < 0) ? 4'b0000 : 4'(1 << m_win);
      exp_idx    = (m_win < 0) ? 2'd0 : 2'(m_win);
      exp_locked = (m_lock != 0);
   endfunction

   function automatic void model_advance();
      int wt, eff, n;
      if (reset) begin
         model_reset();
      end else if (en && m_win >= 0) begin
         if (!lasts[m_win]) begin
            m_lock = 1; m_lock_idx = m_win;
         end else begin
            m_lock = 0;
            wt  = int'((weights >> (WB * m_win)) & 12'h7);
            eff = (wt == 0) ? 1 : wt;
            n   = (m_win == m_owner) ? m_cnt + 1 : 1;
            if (n >= eff) begin
               m_prio = (m_win + 1) % N; m_cnt = 0;
            end else begin
               m_prio = m_win; m_cnt = n;
            end
            m_owner = m_win;
         end
      end
   endfunction

   // Apply inputs just after a rising edge, then move to the sampling edge.
   task automatic drive(input logic e, input logic [3:0] r, input logic [3:0] l, input logic [11:0] w);
      en = e; reqs = r; lasts = l; weights = w;
      model_eval();
      @(negedge clk);
   endtask

   task automatic advance();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; en = 1'b0; reqs = '0; lasts = '0;
      advance();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      drive(1'b0, 4'b0000, 4'b0000, W_ONES);
      checks++;
      if (grants !== 4'b0000 || locked !== 1'b0 || grant_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset_idle: grants=%b locked=%b idx=%0d expected 0000/0/0", grants, locked, grant_idx);
      end
      advance();
      drive(1'b0, 4'b1111, 4'b1111, W_ONES);
      checks++;
      if (grants !== 4'b0001 || grant_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset_priority: grants=%b idx=%0d expected 0001/0", grants, grant_idx);
      end
      advance();
   endtask

   task automatic test_round_robin();
      logic [3:0] seq [8];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'b1111, 4'b1111, W_ONES);
         checks++;
         if (grants !== seq[i] || locked !== 1'b0) begin
            errors++;
            $display("FAIL round_robin[%0d]: grants=%b locked=%b expected %b/0", i, grants, locked, seq[i]);
         end
         advance();
      end
   endtask

   task automatic test_weights();
      logic [3:0] seq [8];
      seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'b0011, 4'b0011, 12'b001_001_001_011);
         checks++;
         if (grants !== seq[i]) begin
            errors++;
            $display("FAIL weights[%0d]: grants=%b expected %b", i, grants, seq[i]);
         end
         advance();
      end
   endtask

   task automatic test_lock();
      logic [3:0] r_t [8];
      logic [3:0] l_t [8];
      logic [3:0] g_t [8];
      logic       k_t [8];
      r_t = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0101, 4'b0101};
      l_t = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0101};
      g_t = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0001, 4'b0100};
      k_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         if (i == 0 || i == 4) apply_reset();
         drive(1'b1, r_t[i], l_t[i], W_ONES);
         checks++;
         if (grants !== g_t[i] || locked !== k_t[i]) begin
            errors++;
            $display("FAIL lock[%0d]: grants=%b locked=%b expected %b/%b", i, grants, locked, g_t[i], k_t[i]);
         end
         advance();
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'b0010, 4'b0000, W_ONES);
         checks++;
         if (grants !== 4'b0010 || locked !== 1'b0 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL stall[%0d]: grants=%b locked=%b idx=%0d expected 0010/0/1", i, grants, locked, grant_idx);
         end
         advance();
      end
      drive(1'b1, 4'b0010, 4'b0000, W_ONES);
      advance();
      drive(1'b0, 4'b0010, 4'b0000, W_ONES);
      checks++;
      if (grants !== 4'b0010 || locked !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: grants=%b locked=%b expected 0010/1", grants, locked);
      end
      advance();
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      drive(1'b1, 4'b1000, 4'b0000, W_ONES);
      advance();
      drive(1'b1, 4'b1000, 4'b0000, W_ONES);
      checks++;
      if (locked !== 1'b1 || grants !== 4'b1000) begin
         errors++;
         $display("FAIL midpkt_locked: grants=%b locked=%b expected 1000/1", grants, locked);
      end
      reset = 1'b1;
      advance();
      reset = 1'b0;
      drive(1'b1, 4'b1001, 4'b0000, W_ONES);
      checks++;
      if (locked !== 1'b0 || grants !== 4'b0001) begin
         errors++;
         $display("FAIL midpkt_reset: grants=%b locked=%b expected 0001/0", grants, locked);
      end
      advance();
   endtask

   task automatic test_weight_zero();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'b0010, 4'b0010, 12'b001_001_000_001);
         checks++;
         if (grants !== 4'b0010) begin
            errors++;
            $display("FAIL weight0[%0d]: grants=%b expected 0010", i, grants);
         end
         advance();
      end
      drive(1'b1, 4'b1111, 4'b1111, 12'b001_001_000_001);
      checks++;
      if (grants !== 4'b0100) begin
         errors++;
         $display("FAIL weight0_rotate: grants=%b expected 0100", grants);
      end
      advance();
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            apply_reset();
         end else begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom & $urandom), 12'($urandom));
            checks++;
            if (grants !== exp_grants || grant_idx !== exp_idx || locked !== exp_locked) begin
               errors++;
               $display("FAIL random[%0d]: grants=%b idx=%0d locked=%b expected %b/%0d/%b",
                        i, grants, grant_idx, locked, exp_grants, exp_idx, exp_locked);
            end
            advance();
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_round_robin();
      test_weights();
      test_lock();
      test_backpressure();
      test_reset_mid_packet();
      test_weight_zero();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
